// File: rtl/fxp_compare_pipe.sv
// Two-stage pipelined comparator for signed Q(INT_W).(FRAC_W) operands with valid/ready flow.
// Optional result counters are enabled by defining FXP_CMP_STATS_EN.
module fxp_compare_pipe #(
  parameter int unsigned INT_W  = 32,
  parameter int unsigned FRAC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INT_W+FRAC_W-1:0]   feature,
  input  logic [INT_W+FRAC_W-1:0]   threshold,
  input  logic [2:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      go_left,
  output logic                      is_equal,
  output logic                      mode_err,
  output logic                      compare_done
`ifdef FXP_CMP_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [15:0]               left_cnt,
  output logic [15:0]               right_cnt
`endif
);

  localparam int unsigned W = INT_W + FRAC_W;

  localparam logic [2:0] ModeLe = 3'd0;
  localparam logic [2:0] ModeLt = 3'd1;
  localparam logic [2:0] ModeGe = 3'd2;
  localparam logic [2:0] ModeGt = 3'd3;
  localparam logic [2:0] ModeEq = 3'd4;
  localparam logic [2:0] ModeNe = 3'd5;

  logic s1_valid_q;
  logic s1_hi_lt_q, s1_hi_eq_q, s1_lo_lt_q, s1_lo_eq_q;
  logic [2:0] s1_mode_q;
  logic out_valid_q, go_left_q, is_equal_q, mode_err_q;

  logic s1_adv, s2_adv;
  logic signed [INT_W-1:0] f_hi, t_hi;
  logic [FRAC_W-1:0] f_lo, t_lo;
  logic lt, eq, go_d, err_d;

  assign s2_adv   = en & (~out_valid_q | out_ready);
  assign s1_adv   = en & (~s1_valid_q | s2_adv);
  assign in_ready = s1_adv;

  assign f_hi = feature[W-1:FRAC_W];
  assign t_hi = threshold[W-1:FRAC_W];
  assign f_lo = feature[FRAC_W-1:0];
  assign t_lo = threshold[FRAC_W-1:0];

  // Integer halves compare signed; fraction halves are plain magnitudes.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_hi_lt_q <= f_hi < t_hi;
      s1_hi_eq_q <= f_hi == t_hi;
      s1_lo_lt_q <= f_lo < t_lo;
      s1_lo_eq_q <= f_lo == t_lo;
      s1_mode_q  <= mode;
    end
  end

  always_comb begin
    lt    = s1_hi_lt_q | (s1_hi_eq_q & s1_lo_lt_q);
    eq    = s1_hi_eq_q & s1_lo_eq_q;
    go_d  = 1'b0;
    err_d = 1'b0;
    case (s1_mode_q)
      ModeLe:  go_d = lt | eq;
      ModeLt:  go_d = lt;
      ModeGe:  go_d = ~lt;
      ModeGt:  go_d = ~(lt | eq);
      ModeEq:  go_d = eq;
      ModeNe:  go_d = ~eq;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      go_left_q   <= 1'b0;
      is_equal_q  <= 1'b0;
      mode_err_q  <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          go_left_q  <= go_d;
          is_equal_q <= eq;
          mode_err_q <= err_d;
        end
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign go_left      = go_left_q;
  assign is_equal     = is_equal_q;
  assign mode_err     = mode_err_q;
  assign compare_done = en & out_valid_q & out_ready;

`ifdef FXP_CMP_STATS_EN
  logic [15:0] left_cnt_q, right_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
    end else if (stat_clr) begin
      left_cnt_q  <= '0;
      right_cnt_q <= '0;
    end else if (compare_done) begin
      if (go_left_q) begin
        if (left_cnt_q != 16'hFFFF) left_cnt_q <= left_cnt_q + 16'd1;
      end else begin
        if (right_cnt_q != 16'hFFFF) right_cnt_q <= right_cnt_q + 16'd1;
      end
    end
  end

  assign left_cnt  = left_cnt_q;
  assign right_cnt = right_cnt_q;
`endif

endmodule

// File: tb/tb_fxp_compare_pipe.sv
// Randomized bench for fxp_compare_pipe: queue-based reference model checked every cycle,
// plus directed cases with hand-computed expectations.
module tb_fxp_compare_pipe;

  localparam int unsigned INT_W  = 32;
  localparam int unsigned FRAC_W = 32;
  localparam int unsigned W      = INT_W + FRAC_W;

  logic clk, rst_n, en, in_valid, in_ready, out_valid, out_ready;
  logic go_left, is_equal, mode_err, compare_done;
  logic [W-1:0] feature, threshold;
  logic [2:0] mode;
`ifdef FXP_CMP_STATS_EN
  logic stat_clr;
  logic [15:0] left_cnt, right_cnt;
  int exp_left, exp_right;
`endif

  fxp_compare_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .feature(feature), .threshold(threshold), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .go_left(go_left), .is_equal(is_equal), .mode_err(mode_err),
    .compare_done(compare_done)
`ifdef FXP_CMP_STATS_EN
    , .stat_clr(stat_clr), .left_cnt(left_cnt), .right_cnt(right_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {go_left, is_equal, mode_err} straight from the signed-value definition.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] f, input logic [W-1:0] t,
                                         input logic [2:0] m);
    logic signed [W-1:0] a, b;
    logic go;
    a = f;
    b = t;
    case (m)
      3'd0: go = a <= b;
      3'd1: go = a < b;
      3'd2: go = a >= b;
      3'd3: go = a > b;
      3'd4: go = a == b;
      3'd5: go = a != b;
      default: go = 1'b0;
    endcase
    return {go, a == b, m > 3'd5};
  endfunction

  typedef struct {
    logic [2:0] res;
    int         stage;
  } ent_t;
  ent_t q[$];

  // Model state describes the pipeline between edges; update it for the coming edge.
  always @(negedge clk) begin
    logic exp_ov, exp_rdy, cons;
    ent_t e;
    if (!rst_n) begin
      q.delete();
`ifdef FXP_CMP_STATS_EN
      exp_left = 0;
      exp_right = 0;
`endif
      chk("rst_out_valid", out_valid, 0);
      chk("rst_go_left", go_left, 0);
      chk("rst_is_equal", is_equal, 0);
      chk("rst_mode_err", mode_err, 0);
      chk("rst_compare_done", compare_done, 0);
    end else begin
      exp_ov  = (q.size() > 0) && (q[0].stage == 2);
      exp_rdy = en && ((q.size() < 2) || out_ready);
      cons    = en && exp_ov && out_ready;
      chk("m_out_valid", out_valid, exp_ov);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_compare_done", compare_done, cons);
      if (exp_ov) begin
        chk("m_go_left", go_left, q[0].res[2]);
        chk("m_is_equal", is_equal, q[0].res[1]);
        chk("m_mode_err", mode_err, q[0].res[0]);
      end
`ifdef FXP_CMP_STATS_EN
      chk("m_left_cnt", left_cnt, exp_left);
      chk("m_right_cnt", right_cnt, exp_right);
      if (stat_clr) begin
        exp_left = 0;
        exp_right = 0;
      end else if (cons) begin
        if (q[0].res[2]) exp_left = (exp_left < 65535) ? exp_left + 1 : 65535;
        else exp_right = (exp_right < 65535) ? exp_right + 1 : 65535;
      end
`endif
      if (cons) void'(q.pop_front());
      if (en && q.size() > 0 && q[0].stage == 1) q[0].stage = 2;
      if (exp_rdy && in_valid) begin
        e.res = ref_cmp(feature, threshold, mode);
        e.stage = 1;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [W-1:0] f, input logic [W-1:0] t, input logic [2:0] m);
    feature = f;
    threshold = t;
    mode = m;
  endtask

  // One isolated transfer with out_ready=1; checks the 2-cycle latency and the flags.
  task automatic single(input string name, input logic [W-1:0] f, input logic [W-1:0] t,
                        input logic [2:0] m, input logic [2:0] exp);
    @(posedge clk); #1;
    en = 1; out_ready = 1; in_valid = 1;
    drive(f, t, m);
    @(negedge clk);
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk({name, "_valid_early"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_flags"}, {go_left, is_equal, mode_err}, exp);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    en = 1; out_ready = 1; in_valid = 0;
`ifdef FXP_CMP_STATS_EN
    stat_clr = 0;
`endif
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] r_f, r_t;
  int sel;

  initial begin
    rst_n = 0; en = 0; in_valid = 0; out_ready = 0;
    drive('0, '0, 3'd0);
`ifdef FXP_CMP_STATS_EN
    stat_clr = 0;
`endif
    repeat (3) @(posedge clk);
    #3 rst_n = 1;

    // Pin the model against hand-computed values.
    chk("pin_le", ref_cmp(64'h00000001_80000000, 64'h00000002_00000000, 3'd0), 3'b100);
    chk("pin_lt_min", ref_cmp(64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 3'd1), 3'b100);
    chk("pin_gt_min", ref_cmp(64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 3'd3), 3'b000);
    chk("pin_gt_lsb", ref_cmp(64'h00000001_00000001, 64'h00000001_00000000, 3'd3), 3'b100);
    chk("pin_rsv", ref_cmp(64'h5, 64'h5, 3'd7), 3'b011);

    single("le_1p5_2p0", 64'h00000001_80000000, 64'h00000002_00000000, 3'd0, 3'b100);
    single("lt_minneg", 64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 3'd1, 3'b100);
    single("gt_minneg", 64'h80000000_00000000, 64'h7FFFFFFF_FFFFFFFF, 3'd3, 3'b000);
    single("gt_lsb", 64'h00000001_00000001, 64'h00000001_00000000, 3'd3, 3'b100);
    single("eq_same", 64'hFFFFFFFF_40000000, 64'hFFFFFFFF_40000000, 3'd4, 3'b110);
    single("rsv7", 64'h00000003_00000000, 64'h00000001_00000000, 3'd7, 3'b001);
    single("ne_frac", 64'hFFFFFFFE_80000000, 64'hFFFFFFFE_7FFFFFFF, 3'd5, 3'b100);
    drain();

    // Backpressure: two absorbed, third stalls, then drains in order with no bubble.
    out_ready = 0; in_valid = 1;
    drive(64'h1_00000000, 64'h2_00000000, 3'd1);
    @(negedge clk); chk("bp_rdy_a", in_ready, 1);
    @(posedge clk); #1;
    drive(64'h1_00000000, 64'h2_00000000, 3'd3);
    @(negedge clk); chk("bp_rdy_b", in_ready, 1);
    @(posedge clk); #1;
    drive(64'h7_00000007, 64'h7_00000007, 3'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy_c_stall", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_a", go_left, 1);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp_rdy_c", in_ready, 1);
    chk("bp_out_a", {out_valid, go_left}, 2'b11);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk); chk("bp_out_b", {out_valid, go_left, is_equal}, 3'b100);
    @(negedge clk); chk("bp_out_c", {out_valid, go_left, is_equal}, 3'b111);
    drain();

    // Randomized traffic, stalls and freezes; the model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      en = ($urandom % 8) != 0;
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
`ifdef FXP_CMP_STATS_EN
      stat_clr = ($urandom % 150) == 0;
`endif
      r_f = {$urandom, $urandom};
      r_t = {$urandom, $urandom};
      sel = $urandom % 4;
      if (sel == 0) r_t = r_f;
      else if (sel == 1) r_t[W-1:FRAC_W] = r_f[W-1:FRAC_W];
      else if (sel == 2) r_t = r_f + W'($urandom_range(0, 2)) - W'(1);
      drive(r_f, r_t, 3'($urandom_range(0, 7)));
    end
    drain();

    // Reset while both stages hold results.
    out_ready = 0; in_valid = 1;
    drive(64'h3, 64'h4, 3'd1);
    @(posedge clk); #1;
    drive(64'h4, 64'h3, 3'd1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk); chk("rst_mid_full", {out_valid, in_ready}, 2'b10);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_go", go_left, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", out_valid, 0);
    end
    single("post_rst", 64'h2, 64'h2, 3'd2, 3'b110);
    drain();

`ifdef FXP_CMP_STATS_EN
    stat_clr = 1;
    @(posedge clk); #1;
    stat_clr = 0;
    @(negedge clk);
    chk("st_clr0", {left_cnt, right_cnt}, 32'h0);
    for (int i = 0; i < 3; i++) single("st_left", 64'h1, 64'h2, 3'd0, 3'b100);
    for (int i = 0; i < 2; i++) single("st_right", 64'h1, 64'h2, 3'd2, 3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_left3", left_cnt, 16'd3);
    chk("st_right2", right_cnt, 16'd2);
    @(posedge clk); #1;
    stat_clr = 1;
    @(posedge clk); #1;
    stat_clr = 0;
    @(negedge clk);
    chk("st_clr1", {left_cnt, right_cnt}, 32'h0);
    en = 1; out_ready = 1; in_valid = 1;
    drive(64'h9, 64'h9, 3'd4);
    repeat (65540) @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("st_sat", left_cnt, 16'hFFFF);
    chk("st_sat_right", right_cnt, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_compare_pipe.md
FXP_COMPARE_PIPE -- requirements
Module: fxp_compare_pipe

Interface
REQ-001 Parameter INT_W, default 32: integer bits, including sign, of the signed fixed-point operands; legal range 1..64.
REQ-002 Parameter FRAC_W, default 32: fraction bits; legal range 1..64; operand width W = INT_W+FRAC_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 en  in  1  global enable; 0 freezes the pipeline.
REQ-006 in_valid  in  1  input operand set valid.
REQ-007 in_ready  out  1  block accepts the input set this cycle.
REQ-008 feature  in  W  signed two's-complement Q(INT_W).(FRAC_W) operand A.
REQ-009 threshold  in  W  signed Q(INT_W).(FRAC_W) operand B.
REQ-010 mode  in  3  0=LE, 1=LT, 2=GE, 3=GT, 4=EQ, 5=NE; 6 and 7 are reserved.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 go_left  out  1  result of "feature <mode> threshold".
REQ-014 is_equal  out  1  feature == threshold.
REQ-015 mode_err  out  1  captured mode was reserved.
REQ-016 compare_done  out  1  out_valid && out_ready; one-cycle pulse per result consumed.

Function
REQ-017 Two register stages, S1 and S2, each with its own valid bit; an input transfers when in_valid && in_ready at a rising edge.
REQ-018 S1 registers: hi_lt (signed compare of bits [W-1:FRAC_W]), hi_eq, lo_lt (unsigned compare of bits [FRAC_W-1:0]), lo_eq, and mode.
REQ-019 S2 computes lt = hi_lt | (hi_eq & lo_lt) and eq = hi_eq & lo_eq, then registers go_left, is_equal and mode_err per mode.
REQ-020 For reserved modes: go_left=0, mode_err=1, is_equal still valid.
REQ-021 Latency with en=1 and out_ready=1: out_valid asserts exactly 2 cycles after the accept edge; throughput is 1 result per cycle.
REQ-022 Advance rules: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = en & s1_adv.
REQ-023 in_ready may depend combinationally on out_ready; no other input-to-output combinational path is permitted.
REQ-024 Backpressure: while out_ready=0 the S2 outputs hold stable; the block absorbs at most 2 results, then deasserts in_ready.
REQ-025 Results leave in acceptance order; no result is dropped or duplicated.
REQ-026 en=0: no stage advances, in_ready=0, outputs hold, and out_valid is unchanged; a pending result is consumed only while en=1.
REQ-027 Simultaneous consume and accept with a full pipeline is supported with no bubble.

Reset
REQ-028 rst_n=0 immediately clears both valid bits and drives out_valid, go_left, is_equal, mode_err and compare_done to 0, independent of clk.
REQ-029 Reset asserted mid-operation discards all in-flight results; after release the first result appears 2 cycles after the first accept.
REQ-030 Datapath registers other than valid and output flags need no reset.

Configuration
REQ-031 Macro FXP_CMP_STATS_EN, when defined, adds these ports: stat_clr in 1; left_cnt out 16; right_cnt out 16.
REQ-032 With the macro defined, each compare_done increments left_cnt if go_left=1, otherwise right_cnt.
REQ-033 Both counters saturate at 0xFFFF; stat_clr=1 synchronously zeroes them with priority over increment; rst_n zeroes them.
REQ-034 Without the macro, the stats ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-035 Default params, mode=LE, feature 0x00000001_80000000 (1.5), threshold 0x00000002_00000000 (2.0) -> go_left=1, is_equal=0, out_valid 2 cycles after accept.
REQ-036 mode=LT, feature 0x80000000_00000000 (min negative), threshold 0x7FFFFFFF_FFFFFFFF -> go_left=1; the same pair with GT -> go_left=0.
REQ-037 mode=GT, feature 0x00000001_00000001, threshold 0x00000001_00000000 (1 LSB) -> go_left=1; mode=EQ on equal operands -> go_left=1, is_equal=1; mode=7 -> go_left=0, mode_err=1.
REQ-038 With out_ready=0, stream 3 back-to-back inputs -> 2 accepted, in_ready=0 on the 3rd, outputs stable; raise out_ready -> results emerge in order on consecutive cycles, then the 3rd is accepted.
REQ-039 Assert rst_n=0 while both stages are valid -> out_valid=0 with no clock edge; after release, no stale result appears.
REQ-040 FXP_CMP_STATS_EN defined: 3 left and 2 right results -> left_cnt=3, right_cnt=2; stat_clr pulse -> both 0; 65536 left results -> left_cnt holds at 0xFFFF.
